// File: rtl/ip_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ip_pkg
// Description : Shared types, constants and helpers for the IPv4 receive
//               path: FSM state encoding, header field constants and the
//               ones-complement carry fold used by the checksum accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
package ip_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HDR     = 3'd1,
    S_OPT     = 3'd2,
    S_PAYLOAD = 3'd3,
    S_DRAIN   = 3'd4,
    S_FIN     = 3'd5
  } ip_state_t;

  localparam logic [3:0] IP_VERSION4 = 4'd4;
  localparam logic [3:0] IHL_MIN     = 4'd5;
  localparam logic [7:0] PROTO_UDP   = 8'd17;
  localparam logic [7:0] PROTO_TCP   = 8'd6;

  // Two carry folds are enough for any accumulator fed by a legal header
  // (at most 15 words, i.e. 30 halves), so no loop is needed.
  function automatic logic [15:0] ones_fold(input logic [31:0] acc);
    logic [16:0] s1;
    logic [16:0] s2;
    s1 = {1'b0, acc[31:16]} + {1'b0, acc[15:0]};
    s2 = {1'b0, s1[15:0]} + {16'd0, s1[16]};
    return s2[15:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/ip_decoder_if.sv
`default_nettype none
// ============================================================================
// Module      : ip_decoder_if
// Description : Bundle of the word-stream input and the parsed-header /
//               payload outputs of the IPv4 decoder.
//               slave  : decoder side (stream in, fields/payload out)
//               master : source/sink side (stream out, fields/payload in)
// Revision    : 1.0 - initial release
// ============================================================================
interface ip_decoder_if;
  logic [31:0] data;
  logic        start;
  logic        data_av;
  logic [3:0]  version;
  logic [3:0]  IHL;
  logic [7:0]  type_of_ser;
  logic [15:0] total_len;
  logic [15:0] identification;
  logic [2:0]  flag;
  logic [12:0] frag_offset;
  logic [7:0]  time_to_live;
  logic [7:0]  protocol;
  logic [31:0] src_ip;
  logic [31:0] dest_ip;
  logic        udp0_tcp1;
  logic [31:0] pkg_data;
  logic        wr_en;
  logic        fin;
  logic        err_hdr;
  logic        err_chksum;
  logic        err_proto;
  logic        err_timeout;
  logic        busy;

  modport slave (
    input  data, start, data_av,
    output version, IHL, type_of_ser, total_len, identification, flag,
           frag_offset, time_to_live, protocol, src_ip, dest_ip, udp0_tcp1,
           pkg_data, wr_en, fin, err_hdr, err_chksum, err_proto,
           err_timeout, busy
  );

  modport master (
    output data, start, data_av,
    input  version, IHL, type_of_ser, total_len, identification, flag,
           frag_offset, time_to_live, protocol, src_ip, dest_ip, udp0_tcp1,
           pkg_data, wr_en, fin, err_hdr, err_chksum, err_proto,
           err_timeout, busy
  );
endinterface
`default_nettype wire

// File: rtl/ip_chksum_acc.sv
`default_nettype none
// ============================================================================
// Module      : ip_chksum_acc
// Description : Internet-checksum accumulator. Adds both 16-bit halves of a
//               32-bit word per add cycle; ok reports whether the folded sum,
//               including the word being added this cycle, equals 0xFFFF.
// Ports       : clk, reset (async, active high)
//               clear - restart the sum (may coincide with add)
//               add   - accumulate word
//               word  - 32-bit input word
//               ok    - folded running sum == 0xFFFF (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module ip_chksum_acc
  import ip_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        add,
  input  logic [31:0] word,
  output logic        ok
);

  logic [31:0] r_acc;
  logic [31:0] w_base;
  logic [31:0] w_acc_next;

  // ok looks through to the value after this cycle's add so the owner can
  // judge the header in the same cycle its last word arrives.
  always_comb begin
    w_base     = clear ? 32'd0 : r_acc;
    w_acc_next = w_base;
    if (add) begin
      w_acc_next = w_base + {16'd0, word[31:16]} + {16'd0, word[15:0]};
    end
    ok = (ones_fold(w_acc_next) == 16'hFFFF);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc <= 32'd0;
    end else if (clear || add) begin
      r_acc <= w_acc_next;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ip_decoder.sv
`default_nettype none
// ============================================================================
// Module      : ip_decoder
// Description : IPv4 receive parser. Captures header fields from a 32-bit
//               word stream, checks version/IHL/length, header checksum and
//               protocol, then forwards payload words (latency 1) or drains
//               them. Starvation mid-packet aborts after TIMEOUT_CYC idle
//               cycles.
// Ports       : clk, reset (async, active high), bus (ip_decoder_if.slave)
// Macro       : IP_DEC_DROP_BAD_CHKSUM_EN - drain instead of forwarding the
//               payload of a packet whose header checksum fails.
// Revision    : 1.0 - initial release
// ============================================================================
module ip_decoder
  import ip_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1024,
  parameter int CNT_W       = 11
) (
  input  logic         clk,
  input  logic         reset,
  ip_decoder_if.slave  bus
);

  localparam logic [CNT_W-1:0] c_timeout = CNT_W'(TIMEOUT_CYC);

  ip_state_t r_state, w_state_next, w_end_target;

  logic [3:0]  r_version, r_ihl, r_hdr_idx;
  logic [7:0]  r_tos, r_ttl, r_protocol;
  logic [15:0] r_total_len, r_ident;
  logic [2:0]  r_flag;
  logic [12:0] r_frag;
  logic [31:0] r_src, r_dst, r_pkg_data;
  logic        r_udp0_tcp1, r_wr_en, r_fin;
  logic        r_err_hdr, r_err_chksum, r_err_proto, r_err_timeout;
  logic [14:0] r_remain;
  logic [CNT_W-1:0] r_idle;

  logic        w_accept, w_w0_ok, w_hdr_word, w_hdr_end, w_xfer, w_last;
  logic        w_active, w_timeout, w_proto_bad, w_drop, w_chk_ok;
  logic [16:0] w_len_sum;
  logic [14:0] w_pay_n;
  logic [CNT_W-1:0] w_idle_next;

  ip_chksum_acc u_chksum (
    .clk   (clk),
    .reset (reset),
    .clear (w_accept),
    .add   (w_accept || w_hdr_word),
    .word  (bus.data),
    .ok    (w_chk_ok)
  );

  always_comb begin
    w_accept    = (r_state == S_IDLE) && bus.start && bus.data_av;
    w_w0_ok     = (bus.data[31:28] == IP_VERSION4) && (bus.data[27:24] >= IHL_MIN) &&
                  (bus.data[15:0] >= {10'd0, bus.data[27:24], 2'b00});
    w_hdr_word  = ((r_state == S_HDR) || (r_state == S_OPT)) && bus.data_av;
    // r_hdr_idx is the index of the header word currently on the bus.
    w_hdr_end   = w_hdr_word && (r_hdr_idx == (r_ihl - 4'd1));
    w_len_sum   = {1'b0, r_total_len} - {11'd0, r_ihl, 2'b00} + 17'd3;
    w_pay_n     = 15'(w_len_sum >> 2);
    w_proto_bad = (r_protocol != PROTO_UDP) && (r_protocol != PROTO_TCP);
`ifdef IP_DEC_DROP_BAD_CHKSUM_EN
    w_drop      = w_proto_bad || !w_chk_ok;
`else
    w_drop      = w_proto_bad;
`endif
    w_xfer      = ((r_state == S_PAYLOAD) || (r_state == S_DRAIN)) && bus.data_av;
    w_last      = w_xfer && (r_remain == 15'd1);
    w_active    = (r_state == S_HDR) || (r_state == S_OPT) ||
                  (r_state == S_PAYLOAD) || (r_state == S_DRAIN);
    w_idle_next = r_idle + CNT_W'(1);
    w_timeout   = w_active && !bus.data_av && (w_idle_next == c_timeout);

    if (w_pay_n == 15'd0) begin
      w_end_target = S_FIN;
    end else if (w_drop) begin
      w_end_target = S_DRAIN;
    end else begin
      w_end_target = S_PAYLOAD;
    end

    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_next = w_w0_ok ? S_HDR : S_FIN;
      end
      S_HDR: begin
        if (w_timeout) w_state_next = S_FIN;
        else if (w_hdr_end) w_state_next = w_end_target;
        else if (w_hdr_word && (r_hdr_idx == 4'd4)) w_state_next = S_OPT;
      end
      S_OPT: begin
        if (w_timeout) w_state_next = S_FIN;
        else if (w_hdr_end) w_state_next = w_end_target;
      end
      S_PAYLOAD, S_DRAIN: begin
        if (w_timeout || w_last) w_state_next = S_FIN;
      end
      S_FIN:   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_version <= '0; r_ihl <= '0; r_tos <= '0; r_total_len <= '0;
      r_ident <= '0; r_flag <= '0; r_frag <= '0; r_ttl <= '0;
      r_protocol <= '0; r_src <= '0; r_dst <= '0; r_udp0_tcp1 <= 1'b0;
      r_pkg_data <= '0; r_wr_en <= 1'b0; r_fin <= 1'b0;
      r_err_hdr <= 1'b0; r_err_chksum <= 1'b0; r_err_proto <= 1'b0;
      r_err_timeout <= 1'b0; r_hdr_idx <= '0; r_remain <= '0; r_idle <= '0;
    end else begin
      r_fin   <= (r_state == S_FIN);
      r_wr_en <= (r_state == S_PAYLOAD) && bus.data_av;
      if ((r_state == S_PAYLOAD) && bus.data_av) r_pkg_data <= bus.data;

      if (w_accept) begin
        r_version     <= bus.data[31:28];
        r_ihl         <= bus.data[27:24];
        r_tos         <= bus.data[23:16];
        r_total_len   <= bus.data[15:0];
        r_err_hdr     <= !w_w0_ok;
        r_err_chksum  <= 1'b0;
        r_err_proto   <= 1'b0;
        r_err_timeout <= 1'b0;
        r_hdr_idx     <= 4'd1;
      end

      if (w_hdr_word) begin
        r_hdr_idx <= r_hdr_idx + 4'd1;
        case (r_hdr_idx)
          4'd1: begin
            r_ident <= bus.data[31:16];
            r_flag  <= bus.data[15:13];
            r_frag  <= bus.data[12:0];
          end
          4'd2: begin
            r_ttl       <= bus.data[31:24];
            r_protocol  <= bus.data[23:16];
            r_udp0_tcp1 <= (bus.data[23:16] == PROTO_TCP);
          end
          4'd3:    r_src <= bus.data;
          4'd4:    r_dst <= bus.data;
          default: ;
        endcase
      end

      if (w_hdr_end) begin
        r_err_chksum <= !w_chk_ok;
        r_err_proto  <= w_proto_bad;
        r_remain     <= w_pay_n;
      end else if (w_xfer) begin
        r_remain <= r_remain - 15'd1;
      end

      if (w_active && !bus.data_av) r_idle <= w_idle_next;
      else                          r_idle <= '0;
      if (w_timeout) r_err_timeout <= 1'b1;
    end
  end

  assign bus.version        = r_version;
  assign bus.IHL            = r_ihl;
  assign bus.type_of_ser    = r_tos;
  assign bus.total_len      = r_total_len;
  assign bus.identification = r_ident;
  assign bus.flag           = r_flag;
  assign bus.frag_offset    = r_frag;
  assign bus.time_to_live   = r_ttl;
  assign bus.protocol       = r_protocol;
  assign bus.src_ip         = r_src;
  assign bus.dest_ip        = r_dst;
  assign bus.udp0_tcp1      = r_udp0_tcp1;
  assign bus.pkg_data       = r_pkg_data;
  assign bus.wr_en          = r_wr_en;
  assign bus.fin            = r_fin;
  assign bus.err_hdr        = r_err_hdr;
  assign bus.err_chksum     = r_err_chksum;
  assign bus.err_proto      = r_err_proto;
  assign bus.err_timeout    = r_err_timeout;
  assign bus.busy           = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ip_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_ip_decoder
// Description : Self-checking bench for ip_decoder. Payload words are pushed
//               to a scoreboard queue as they are driven and compared when
//               wr_en appears; header fields, error flags and fin timing are
//               checked per scenario.
// Macro       : IP_DEC_DROP_BAD_CHKSUM_EN (changes expected payload count)
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ip_decoder;

  localparam int TO = 1024;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ip_decoder_if bus();

  ip_decoder #(.TIMEOUT_CYC(TO), .CNT_W(11)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] pkt_q[$];
  int cyc = 0, fin_cnt = 0, fin_cyc = 0, last_wr_cyc = 0, wr_cnt = 0;
  logic prev_fin = 1'b0;

  // Scoreboard side: every wr_en pops one expected word.
  always @(negedge clk) begin
    logic [31:0] e;
    cyc++;
    if (bus.wr_en === 1'b1) begin
      wr_cnt++;
      last_wr_cyc = cyc;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL wr_unexpected got=%h want=none", bus.pkg_data);
      end else begin
        e = exp_q.pop_front();
        if (bus.pkg_data !== e) begin
          failures++;
          $display("FAIL pkg_data got=%h want=%h", bus.pkg_data, e);
        end
      end
    end
    if (bus.fin === 1'b1) begin
      fin_cnt++;
      fin_cyc = cyc;
      checks++;
      if (prev_fin) begin
        failures++;
        $display("FAIL fin_width got=2+ cycles want=1");
      end
    end
    prev_fin = bus.fin;
  end

  function automatic logic [15:0] bench_csum(input int n);
    int unsigned s = 0;
    for (int i = 0; i < n; i++) s += pkt_q[i][31:16] + pkt_q[i][15:0];
    while ((s >> 16) != 0) s = (s & 32'hFFFF) + (s >> 16);
    return ~s[15:0];
  endfunction

  task automatic build_fixed(input logic [31:0] w2);
    pkt_q.delete();
    pkt_q.push_back(32'h45000073); pkt_q.push_back(32'h00004000);
    pkt_q.push_back(w2);           pkt_q.push_back(32'hC0A80001);
    pkt_q.push_back(32'hC0A800C7);
    for (int i = 0; i < 24; i++) pkt_q.push_back($urandom);
  endtask

  task automatic build_hdr(input logic [3:0] ihl, input logic [15:0] tlen,
                           input logic [7:0] proto, input int npay);
    logic [31:0] t;
    pkt_q.delete();
    pkt_q.push_back({4'h4, ihl, 8'h00, tlen});
    pkt_q.push_back(32'h12344000);
    pkt_q.push_back({8'h40, proto, 16'h0000});
    pkt_q.push_back(32'hC0A80001);
    pkt_q.push_back(32'hC0A8000A);
    for (int i = 5; i < ihl; i++) pkt_q.push_back(32'hA0B0C000 + i);
    t = pkt_q[2];
    t[15:0] = bench_csum(int'(ihl));
    pkt_q[2] = t;
    for (int i = 0; i < npay; i++) pkt_q.push_back($urandom);
  endtask

  task automatic drive_pkt(input int n_hdr, input bit fwd);
    @(posedge clk); #1;
    for (int i = 0; i < pkt_q.size(); i++) begin
      bus.data = pkt_q[i];
      bus.start = (i == 0);
      bus.data_av = 1'b1;
      if (fwd && i >= n_hdr) exp_q.push_back(pkt_q[i]);
      @(posedge clk); #1;
    end
    bus.data_av = 1'b0;
    bus.start = 1'b0;
    bus.data = 32'd0;
  endtask

  task automatic wait_fin(input int base);
    int n = 0;
    while (fin_cnt == base && n < TO + 100) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    checks++;
    if (fin_cnt != base + 1) begin
      failures++;
      $display("FAIL fin_count got=%0d want=%0d", fin_cnt - base, 1);
    end
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.data = 32'd0; bus.start = 1'b0; bus.data_av = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.version, bus.IHL, bus.total_len, bus.src_ip, bus.dest_ip, bus.pkg_data,
         bus.wr_en, bus.fin, bus.err_hdr, bus.err_chksum, bus.err_proto,
         bus.err_timeout, bus.busy, bus.udp0_tcp1} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=nonzero want=0");
    end
    reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_busy got=%b want=0", bus.busy);
    end
  endtask

  task automatic test_udp_good;
    int bf = fin_cnt, bw = wr_cnt;
    build_fixed(32'h4011B861);
    drive_pkt(5, 1'b1);
    wait_fin(bf);
    checks += 14;
    if (bus.version !== 4'd4) begin failures++; $display("FAIL udp_version got=%h want=4", bus.version); end
    if (bus.IHL !== 4'd5) begin failures++; $display("FAIL udp_ihl got=%h want=5", bus.IHL); end
    if (bus.type_of_ser !== 8'h00) begin failures++; $display("FAIL udp_tos got=%h want=00", bus.type_of_ser); end
    if (bus.total_len !== 16'h0073) begin failures++; $display("FAIL udp_total_len got=%h want=0073", bus.total_len); end
    if ({bus.identification, bus.flag, bus.frag_offset} !== {16'h0000, 3'b010, 13'h0}) begin
      failures++; $display("FAIL udp_id_flag got=%h/%b/%h want=0000/010/0000", bus.identification, bus.flag, bus.frag_offset); end
    if (bus.time_to_live !== 8'h40) begin failures++; $display("FAIL udp_ttl got=%h want=40", bus.time_to_live); end
    if (bus.protocol !== 8'h11) begin failures++; $display("FAIL udp_proto got=%h want=11", bus.protocol); end
    if (bus.src_ip !== 32'hC0A80001) begin failures++; $display("FAIL udp_src got=%h want=C0A80001", bus.src_ip); end
    if (bus.dest_ip !== 32'hC0A800C7) begin failures++; $display("FAIL udp_dst got=%h want=C0A800C7", bus.dest_ip); end
    if (bus.udp0_tcp1 !== 1'b0) begin failures++; $display("FAIL udp_sel got=%b want=0", bus.udp0_tcp1); end
    if ({bus.err_hdr, bus.err_chksum, bus.err_proto, bus.err_timeout} !== 4'b0000) begin
      failures++; $display("FAIL udp_errs got=%b want=0000", {bus.err_hdr, bus.err_chksum, bus.err_proto, bus.err_timeout}); end
    if (wr_cnt - bw != 24) begin failures++; $display("FAIL udp_wr_count got=%0d want=24", wr_cnt - bw); end
    if (fin_cyc != last_wr_cyc + 1) begin failures++; $display("FAIL udp_fin_timing got=%0d want=%0d", fin_cyc, last_wr_cyc + 1); end
    if (exp_q.size() != 0 || bus.busy !== 1'b0) begin
      failures++; $display("FAIL udp_leftover got=%0d/%b want=0/0", exp_q.size(), bus.busy); end
  endtask

  task automatic test_bad_chksum;
    int bf = fin_cnt, bw = wr_cnt;
    bit fwd;
`ifdef IP_DEC_DROP_BAD_CHKSUM_EN
    fwd = 1'b0;
`else
    fwd = 1'b1;
`endif
    build_fixed(32'h4011B862);
    drive_pkt(5, fwd);
    wait_fin(bf);
    checks += 3;
    if ({bus.err_hdr, bus.err_chksum, bus.err_proto, bus.err_timeout} !== 4'b0100) begin
      failures++; $display("FAIL chk_errs got=%b want=0100", {bus.err_hdr, bus.err_chksum, bus.err_proto, bus.err_timeout}); end
    if (wr_cnt - bw != (fwd ? 24 : 0)) begin
      failures++; $display("FAIL chk_wr_count got=%0d want=%0d", wr_cnt - bw, fwd ? 24 : 0); end
    if (exp_q.size() != 0) begin failures++; $display("FAIL chk_leftover got=%0d want=0", exp_q.size()); end
  endtask

  task automatic test_options_tcp;
    int bf = fin_cnt, bw = wr_cnt;
    build_hdr(4'd6, 16'd32, 8'd6, 2);
    drive_pkt(6, 1'b1);
    wait_fin(bf);
    checks += 5;
    if ({bus.IHL, bus.total_len, bus.protocol} !== {4'd6, 16'd32, 8'd6}) begin
      failures++; $display("FAIL opt_fields got=%h/%h/%h want=6/0020/06", bus.IHL, bus.total_len, bus.protocol); end
    if (bus.udp0_tcp1 !== 1'b1) begin failures++; $display("FAIL opt_sel got=%b want=1", bus.udp0_tcp1); end
    if ({bus.err_hdr, bus.err_chksum, bus.err_proto, bus.err_timeout} !== 4'b0000) begin
      failures++; $display("FAIL opt_errs got=%b want=0000", {bus.err_hdr, bus.err_chksum, bus.err_proto, bus.err_timeout}); end
    if (wr_cnt - bw != 2) begin failures++; $display("FAIL opt_wr_count got=%0d want=2", wr_cnt - bw); end
    if (fin_cyc != last_wr_cyc + 1) begin failures++; $display("FAIL opt_fin_timing got=%0d want=%0d", fin_cyc, last_wr_cyc + 1); end
  endtask

  task automatic test_bad_hdr;
    int bf = fin_cnt, bw = wr_cnt, c;
    pkt_q.delete();
    pkt_q.push_back(32'h44000014);
    drive_pkt(1, 1'b0);
    c = cyc;
    wait_fin(bf);
    checks += 4;
    if ({bus.err_hdr, bus.err_chksum, bus.err_proto, bus.err_timeout} !== 4'b1000) begin
      failures++; $display("FAIL hdr_errs got=%b want=1000", {bus.err_hdr, bus.err_chksum, bus.err_proto, bus.err_timeout}); end
    if (bus.IHL !== 4'd4) begin failures++; $display("FAIL hdr_ihl got=%h want=4", bus.IHL); end
    if (fin_cyc != c + 2) begin failures++; $display("FAIL hdr_fin_timing got=%0d want=%0d", fin_cyc, c + 2); end
    if (wr_cnt != bw || bus.busy !== 1'b0) begin
      failures++; $display("FAIL hdr_idle got=%0d/%b want=0/0", wr_cnt - bw, bus.busy); end
  endtask

  task automatic test_bad_proto;
    int bf = fin_cnt, bw = wr_cnt, c;
    build_hdr(4'd5, 16'd28, 8'd1, 2);
    drive_pkt(5, 1'b0);
    c = cyc;
    wait_fin(bf);
    checks += 4;
    if ({bus.err_hdr, bus.err_chksum, bus.err_proto, bus.err_timeout} !== 4'b0010) begin
      failures++; $display("FAIL proto_errs got=%b want=0010", {bus.err_hdr, bus.err_chksum, bus.err_proto, bus.err_timeout}); end
    if (bus.protocol !== 8'd1) begin failures++; $display("FAIL proto_field got=%h want=01", bus.protocol); end
    if (wr_cnt != bw) begin failures++; $display("FAIL proto_wr_count got=%0d want=0", wr_cnt - bw); end
    if (fin_cyc != c + 2) begin failures++; $display("FAIL proto_drain_len got=%0d want=%0d", fin_cyc, c + 2); end
  endtask

  task automatic test_timeout;
    int bf = fin_cnt, bw = wr_cnt, c;
    build_hdr(4'd5, 16'd40, 8'd17, 5);
    while (pkt_q.size() > 3) void'(pkt_q.pop_back());
    drive_pkt(5, 1'b0);
    c = cyc;
    wait_fin(bf);
    checks += 3;
    if ({bus.err_hdr, bus.err_chksum, bus.err_proto, bus.err_timeout} !== 4'b0001) begin
      failures++; $display("FAIL to_errs got=%b want=0001", {bus.err_hdr, bus.err_chksum, bus.err_proto, bus.err_timeout}); end
    if (fin_cyc - c < TO || fin_cyc - c > TO + 3) begin
      failures++; $display("FAIL to_delay got=%0d want=%0d..%0d", fin_cyc - c, TO, TO + 3); end
    if (wr_cnt != bw) begin failures++; $display("FAIL to_wr_count got=%0d want=0", wr_cnt - bw); end
    // A fresh packet after the abort must decode cleanly.
    bf = fin_cnt; bw = wr_cnt;
    build_fixed(32'h4011B861);
    drive_pkt(5, 1'b1);
    wait_fin(bf);
    checks += 3;
    if ({bus.err_hdr, bus.err_chksum, bus.err_proto, bus.err_timeout} !== 4'b0000) begin
      failures++; $display("FAIL to_recover_errs got=%b want=0000", {bus.err_hdr, bus.err_chksum, bus.err_proto, bus.err_timeout}); end
    if (bus.dest_ip !== 32'hC0A800C7) begin failures++; $display("FAIL to_recover_dst got=%h want=C0A800C7", bus.dest_ip); end
    if (wr_cnt - bw != 24) begin failures++; $display("FAIL to_recover_wr got=%0d want=24", wr_cnt - bw); end
  endtask

  task automatic test_reset_mid;
    build_fixed(32'h4011B861);
    while (pkt_q.size() > 10) void'(pkt_q.pop_back());
    drive_pkt(5, 1'b1);
    checks++;
    if (bus.wr_en !== 1'b1 || bus.busy !== 1'b1) begin
      failures++; $display("FAIL mid_active got=%b/%b want=1/1", bus.wr_en, bus.busy); end
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.version, bus.IHL, bus.type_of_ser, bus.total_len, bus.identification, bus.flag,
         bus.frag_offset, bus.time_to_live, bus.protocol, bus.src_ip, bus.dest_ip,
         bus.udp0_tcp1, bus.pkg_data, bus.wr_en, bus.fin, bus.err_hdr, bus.err_chksum,
         bus.err_proto, bus.err_timeout, bus.busy} !== '0) begin
      failures++; $display("FAIL mid_reset_outputs got=nonzero want=0");
    end
    @(negedge clk);
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.wr_en !== 1'b0) begin
      failures++; $display("FAIL mid_after got=%b/%b want=0/0", bus.busy, bus.wr_en); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_udp_good();
    test_bad_chksum();
    test_options_tcp();
    test_bad_hdr();
    test_bad_proto();
    test_timeout();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
